// File: rtl/de_selector_pkg.sv
`default_nettype none
// ============================================================================
// Module  : de_selector_pkg
// Purpose : Shared mode/state encodings and widths for the de_selector_n slice.
// Rev     : 1.0  initial release
// ============================================================================
package de_selector_pkg;

    localparam logic MODE_ADDR = 1'b0;
    localparam logic MODE_SCAN = 1'b1;

    localparam int STAT_W = 16;

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

endpackage : de_selector_pkg
`default_nettype wire

// File: rtl/de_selector_n_if.sv
`default_nettype none
// ============================================================================
// Module  : de_selector_n_if
// Purpose : Producer-side stream plus N-channel consumer bundle of de_selector_n.
// Rev     : 1.0  initial release
// ============================================================================
interface de_selector_n_if #(
    parameter int DW = 8,
    parameter int N  = 4,
    parameter int SW = $clog2(N)
);
    logic [DW-1:0] iData;
    logic          iValid;
    logic          oReady;
    logic [SW-1:0] iSel;
    logic          iMode;
    logic [DW-1:0] oData;
    logic [N-1:0]  oValid;
    logic [N-1:0]  iReady;
    logic          oErr;

    modport slave (
        input  iData, iValid, iSel, iMode, iReady,
        output oReady, oData, oValid, oErr
    );

    modport master (
        output iData, iValid, iSel, iMode, iReady,
        input  oReady, oData, oValid, oErr
    );
endinterface : de_selector_n_if
`default_nettype wire

// File: rtl/de_selector_rr_ptr.sv
`default_nettype none
// ============================================================================
// Module  : de_selector_rr_ptr
// Purpose : Modulo-N wrap counter with enable; serves as the scan pointer.
// Rev     : 1.0  initial release
// ============================================================================
module de_selector_rr_ptr #(
    parameter int N  = 4,
    parameter int SW = $clog2(N)
) (
    input  wire logic          clk,
    input  wire logic          rst,
    input  wire logic          i_en,
    output logic [SW-1:0]      o_cnt
);
    logic [SW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= (r_cnt == SW'(N - 1)) ? '0 : r_cnt + SW'(1);
        end
    end

    assign o_cnt = r_cnt;
endmodule : de_selector_rr_ptr
`default_nettype wire

// File: rtl/de_selector_n.sv
`default_nettype none
// ============================================================================
// Module  : de_selector_n
// Purpose : Registered 1-to-N demux with valid/ready; addressed or round-robin.
//           Optional per-channel delivery counters under DE_SELECTOR_STATS_EN.
// Rev     : 1.0  initial release
// ============================================================================
module de_selector_n
    import de_selector_pkg::*;
#(
    parameter int DW = 8,
    parameter int N  = 4,
    parameter int SW = $clog2(N)
) (
    input  wire logic        iClk,
    input  wire logic        iRst,
    de_selector_n_if.slave   bus
`ifdef DE_SELECTOR_STATS_EN
    ,
    input  wire logic [SW-1:0]  iStatSel,
    output logic [STAT_W-1:0]   oStatCnt
`endif
);
    state_t        r_state;
    state_t        w_state_nxt;
    logic [DW-1:0] r_data;
    logic [SW-1:0] r_ch;
    logic          r_err;

    logic          w_ready;
    logic          w_drain;
    logic          w_accept;
    logic          w_oor;
    logic          w_load;
    logic          w_ptr_en;
    logic [SW-1:0] w_ptr;
    logic [SW-1:0] w_dest;

    // Only the held beat's destination ready matters; other channels are ignored.
    assign w_drain  = (r_state == FULL) && bus.iReady[r_ch];
    assign w_ready  = (r_state == EMPTY) || bus.iReady[r_ch];
    assign w_accept = bus.iValid && w_ready;
    assign w_oor    = (bus.iMode == MODE_ADDR) && (32'(bus.iSel) >= N);
    assign w_load   = w_accept && !w_oor;
    assign w_dest   = (bus.iMode == MODE_SCAN) ? w_ptr : bus.iSel;
    assign w_ptr_en = w_load && (bus.iMode == MODE_SCAN);

    de_selector_rr_ptr #(
        .N  (N),
        .SW (SW)
    ) u_rr_ptr (
        .clk   (iClk),
        .rst   (iRst),
        .i_en  (w_ptr_en),
        .o_cnt (w_ptr)
    );

    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            EMPTY:   if (w_load) w_state_nxt = FULL;
            FULL:    if (w_load) w_state_nxt = FULL;
                     else if (w_drain) w_state_nxt = EMPTY;
            default: w_state_nxt = EMPTY;
        endcase
    end

    always_comb begin
        bus.oValid = '0;
        if (r_state == FULL) begin
            bus.oValid[r_ch] = 1'b1;
        end
        bus.oReady = w_ready;
        bus.oData  = r_data;
        bus.oErr   = r_err;
    end

    // A dropped beat still consumes the handshake; it only raises the error pulse.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_data <= '0;
            r_ch   <= '0;
            r_err  <= 1'b0;
        end else begin
            r_err <= w_accept && w_oor;
            if (w_load) begin
                r_data <= bus.iData;
                r_ch   <= w_dest;
            end
        end
    end

`ifdef DE_SELECTOR_STATS_EN
    logic [STAT_W-1:0] r_cnt [N];

    always_ff @(posedge iClk) begin
        if (iRst) begin
            for (int i = 0; i < N; i++) begin
                r_cnt[i] <= '0;
            end
        end else if (w_drain) begin
            r_cnt[r_ch] <= r_cnt[r_ch] + STAT_W'(1);
        end
    end

    assign oStatCnt = (32'(iStatSel) < N) ? r_cnt[iStatSel] : '0;
`endif

endmodule : de_selector_n
`default_nettype wire

// File: tb/tb_de_selector_n.sv
`default_nettype none
// ============================================================================
// Module  : tb_de_selector_n
// Purpose : Directed and random checks of de_selector_n (N=4 and N=3 instances)
//           against a transaction-level reference model.
// Rev     : 1.0  initial release
// ============================================================================
module tb_de_selector_n;
    import de_selector_pkg::*;

    logic iClk = 1'b0;
    logic iRst = 1'b1;
    always #5 iClk = ~iClk;

    de_selector_n_if #(.DW(8), .N(4)) if4 ();
    de_selector_n_if #(.DW(8), .N(3)) if3 ();

`ifdef DE_SELECTOR_STATS_EN
    logic [1:0]  ss4 = '0;
    logic [1:0]  ss3 = '0;
    logic [15:0] sc4;
    logic [15:0] sc3;
`endif

    de_selector_n #(.DW(8), .N(4)) u_dut4 (
        .iClk (iClk),
        .iRst (iRst),
        .bus  (if4)
`ifdef DE_SELECTOR_STATS_EN
        ,
        .iStatSel (ss4),
        .oStatCnt (sc4)
`endif
    );

    de_selector_n #(.DW(8), .N(3)) u_dut3 (
        .iClk (iClk),
        .iRst (iRst),
        .bus  (if3)
`ifdef DE_SELECTOR_STATS_EN
        ,
        .iStatSel (ss3),
        .oStatCnt (sc3)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: index 0 is the N=4 instance, index 1 the N=3 instance.
    bit          m_full [2];
    logic [7:0]  m_data [2];
    int          m_ch   [2];
    int          m_ptr  [2];
    bit          m_err  [2];
    logic [15:0] m_cnt  [2][4];

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic drive(input int k, input bit v, input logic md, input int sel,
                         input logic [7:0] d, input logic [3:0] rdy);
        if (k == 0) begin
            if4.iValid = v; if4.iMode = md; if4.iSel = 2'(sel);
            if4.iData  = d; if4.iReady = rdy;
        end else begin
            if3.iValid = v; if3.iMode = md; if3.iSel = 2'(sel);
            if3.iData  = d; if3.iReady = rdy[2:0];
        end
    endtask

    task automatic idle_all();
        drive(0, 1'b0, MODE_ADDR, 0, 8'h00, 4'hF);
        drive(1, 1'b0, MODE_ADDR, 0, 8'h00, 4'hF);
    endtask

    // One clock: check ready, advance the model, then check registered outputs.
    task automatic step(input bit do_chk);
        int n, sel;
        bit v, md, rdy_act, exp_ready, drain, acc;
        logic [7:0] d;
        logic [3:0] rdy;
        #1;
        for (int k = 0; k < 2; k++) begin
            if (k == 0) begin
                n = 4; v = if4.iValid; md = if4.iMode; sel = int'(if4.iSel);
                d = if4.iData; rdy = if4.iReady; rdy_act = if4.oReady;
            end else begin
                n = 3; v = if3.iValid; md = if3.iMode; sel = int'(if3.iSel);
                d = if3.iData; rdy = {1'b0, if3.iReady}; rdy_act = if3.oReady;
            end
            drain     = m_full[k] && rdy[m_ch[k]];
            exp_ready = !m_full[k] || rdy[m_ch[k]];
            if (do_chk) check_val($sformatf("ready%0d", n), 32'(rdy_act), 32'(exp_ready));
            acc = v && exp_ready;
            if (iRst) begin
                m_full[k] = 0; m_data[k] = 0; m_ch[k] = 0; m_ptr[k] = 0; m_err[k] = 0;
                for (int c = 0; c < 4; c++) m_cnt[k][c] = 0;
            end else begin
                m_err[k] = 0;
                if (drain) begin
                    m_full[k] = 0;
                    m_cnt[k][m_ch[k]] = m_cnt[k][m_ch[k]] + 16'd1;
                end
                if (acc) begin
                    if (md == MODE_ADDR && sel >= n) begin
                        m_err[k] = 1;
                    end else begin
                        m_full[k] = 1;
                        m_data[k] = d;
                        m_ch[k]   = (md == MODE_SCAN) ? m_ptr[k] : sel;
                        if (md == MODE_SCAN) m_ptr[k] = (m_ptr[k] + 1) % n;
                    end
                end
            end
        end
        @(posedge iClk);
        #1;
        if (do_chk) begin
            check_val("err4", 32'(if4.oErr), 32'(m_err[0]));
            check_val("err3", 32'(if3.oErr), 32'(m_err[1]));
            check_val("valid4", 32'(if4.oValid), m_full[0] ? (32'd1 << m_ch[0]) : 32'd0);
            check_val("valid3", 32'(if3.oValid), m_full[1] ? (32'd1 << m_ch[1]) : 32'd0);
            if (m_full[0]) check_val("data4", 32'(if4.oData), 32'(m_data[0]));
            if (m_full[1]) check_val("data3", 32'(if3.oData), 32'(m_data[1]));
`ifdef DE_SELECTOR_STATS_EN
            check_val("stat4", 32'(sc4), 32'(m_cnt[0][ss4]));
            check_val("stat3", 32'(sc3), (ss3 < 3) ? 32'(m_cnt[1][ss3]) : 32'd0);
`endif
        end
    endtask

    int exp_dest [7] = '{0, 1, 2, 0, 1, 2, 0};

    initial begin
        idle_all();
        // Reset state
        iRst = 1'b1;
        step(1'b0);
        step(1'b1);
        check_val("rst_data4", 32'(if4.oData), 32'h0);
        check_val("rst_data3", 32'(if3.oData), 32'h0);
        check_val("rst_valid4", 32'(if4.oValid), 32'h0);
        iRst = 1'b0;

        // Addressed routing, back-to-back
        for (int i = 0; i < 4; i++) begin
            drive(0, 1'b1, MODE_ADDR, i, 8'hA0 + 8'(i), 4'hF);
            step(1'b1);
            check_val("route_onehot", 32'(if4.oValid), 32'd1 << i);
            check_val("route_data", 32'(if4.oData), 32'hA0 + 32'(i));
        end

        // Back-pressure on channel 2, then drain with no bubble
        drive(0, 1'b1, MODE_ADDR, 2, 8'h55, 4'b1011);
        step(1'b1);
        drive(0, 1'b1, MODE_ADDR, 1, 8'h66, 4'b1011);
        for (int i = 0; i < 3; i++) begin
            #1;
            check_val("bp_ready", 32'(if4.oReady), 32'h0);
            step(1'b1);
            check_val("bp_hold", 32'(if4.oData), 32'h55);
        end
        drive(0, 1'b1, MODE_ADDR, 1, 8'h66, 4'hF);
        #1;
        check_val("bp_release_ready", 32'(if4.oReady), 32'h1);
        step(1'b1);
        check_val("bp_next_data", 32'(if4.oData), 32'h66);
        check_val("bp_next_valid", 32'(if4.oValid), 32'b0010);
        idle_all();
        step(1'b1);

        // Scan wrap on N=3
        for (int i = 0; i < 7; i++) begin
            drive(1, 1'b1, MODE_SCAN, 3, 8'h10 + 8'(i), 4'hF);
            step(1'b1);
            check_val("scan_dest", 32'(if3.oValid), 32'd1 << exp_dest[i]);
        end
        idle_all();
        step(1'b1);
        drive(1, 1'b1, MODE_SCAN, 0, 8'h20, 4'hF);
        step(1'b1);
        check_val("scan_ptr_after", 32'(if3.oValid), 32'b010);
        idle_all();
        step(1'b1);

        // Out-of-range select drops the beat
        drive(1, 1'b1, MODE_ADDR, 3, 8'h77, 4'hF);
        step(1'b1);
        check_val("oor_err", 32'(if3.oErr), 32'h1);
        check_val("oor_valid", 32'(if3.oValid), 32'h0);
        idle_all();
        step(1'b1);
        check_val("oor_err_pulse", 32'(if3.oErr), 32'h0);
        drive(1, 1'b1, MODE_SCAN, 0, 8'h21, 4'hF);
        step(1'b1);
        check_val("oor_ptr_kept", 32'(if3.oValid), 32'b100);

        // Reset while FULL
        drive(0, 1'b1, MODE_ADDR, 3, 8'h99, 4'h0);
        drive(1, 1'b1, MODE_SCAN, 0, 8'h98, 4'h0);
        step(1'b1);
        iRst = 1'b1;
        step(1'b1);
        check_val("rstf_valid4", 32'(if4.oValid), 32'h0);
        check_val("rstf_data4", 32'(if4.oData), 32'h0);
        check_val("rstf_ready3", 32'(if3.oReady), 32'h1);
        check_val("rstf_data3", 32'(if3.oData), 32'h0);
        iRst = 1'b0;
        drive(1, 1'b1, MODE_SCAN, 0, 8'h31, 4'hF);
        step(1'b1);
        check_val("rstf_ptr0", 32'(if3.oValid), 32'b001);

        // Randomized traffic with occasional resets and mode changes
        for (int i = 0; i < 2000; i++) begin
            iRst = ($urandom_range(0, 99) == 0);
            for (int k = 0; k < 2; k++) begin
                drive(k, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                      $urandom_range(0, 3), 8'($urandom), 4'($urandom));
            end
`ifdef DE_SELECTOR_STATS_EN
            ss4 = 2'($urandom_range(0, 3));
            ss3 = 2'($urandom_range(0, 3));
`endif
            step(1'b1);
        end
        iRst = 1'b0;

`ifdef DE_SELECTOR_STATS_EN
        // Delivery counters and 16-bit wrap
        idle_all();
        iRst = 1'b1;
        step(1'b1);
        iRst = 1'b0;
        for (int i = 0; i < 7; i++) begin
            drive(0, 1'b1, MODE_ADDR, (i < 5) ? 1 : 0, 8'(i), 4'hF);
            step(1'b1);
        end
        idle_all();
        step(1'b1);
        ss4 = 2'd1; #1;
        check_val("stat_ch1", 32'(sc4), 32'd5);
        ss4 = 2'd0; #1;
        check_val("stat_ch0", 32'(sc4), 32'd2);
        ss3 = 2'd3; #1;
        check_val("stat_oor", 32'(sc3), 32'd0);
        ss4 = 2'd3;
        drive(0, 1'b1, MODE_ADDR, 3, 8'hEE, 4'hF);
        for (int i = 0; i < 65535; i++) step(1'b0);
        idle_all();
        step(1'b1);
        check_val("stat_ffff", 32'(sc4), 32'hFFFF);
        drive(0, 1'b1, MODE_ADDR, 3, 8'hEF, 4'hF);
        step(1'b1);
        idle_all();
        step(1'b1);
        check_val("stat_wrap", 32'(sc4), 32'h0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule : tb_de_selector_n
`default_nettype wire

// File: doc/de_selector_n.md
# de_selector_n

Registered, parametrised 1-to-N demultiplexer with a valid/ready handshake. It is the successor to the 1-to-4 combinational de-selector. One input stream is steered to one of N output channels, either by an explicit select or by an internal round-robin scan pointer. A one-entry output register gives full throughput and back-pressure per channel. It sits between a single producer and N independent consumers.

## Interface
- `DW`, default 8: data width in bits.
- `N`, default 4: number of output channels, N ≥ 2; need not be a power of two.
- `SW`, default $clog2(N): select width; derived, not to be overridden.

Ports:
- `iClk`, input, 1: clock.
- `iRst`, input, 1: synchronous reset, active-high.
- `iData`, input, DW: input beat.
- `iValid`, input, 1: input beat valid.
- `oReady`, output, 1: block can accept a beat this cycle.
- `iSel`, input, SW: destination channel; used in addressed mode only.
- `iMode`, input, 1: 0 = addressed, 1 = round-robin scan.
- `oData`, output, DW: held beat, broadcast to all channels.
- `oValid`, output, N: one-hot; the bit for the destination channel is set while a beat is held.
- `iReady`, input, N: per-channel consumer ready.
- `oErr`, output, 1: one-cycle pulse when a beat is dropped because of an out-of-range `iSel`.
- `iStatSel`, input, SW: statistics channel select. Present only with `DE_SELECTOR_STATS_EN`.
- `oStatCnt`, output, 16: delivered-beat count for channel `iStatSel`. Present only with `DE_SELECTOR_STATS_EN`.

## Operation
- **States:**
  - EMPTY: no beat held; `oValid` = 0.
  - FULL: one beat held in `oData`; destination in `ch_q`.
- **Reset values:** state EMPTY, `oValid` = 0, `oData` = 0, `oErr` = 0, scan pointer = 0, stat counters = 0.
- **Handshakes:**
  - Accept occurs when `iValid && oReady`.
  - Drain occurs when state is FULL and `iReady[ch_q]` is 1.
- **oReady:** `oReady = (state == EMPTY) || iReady[ch_q]`. This is combinational from `iReady`; there is no combinational path from `iValid`.
- **Destination:**
  - Addressed mode: destination is `iSel`.
  - Scan mode: destination is the scan pointer; `iSel` is ignored.
- **Scan pointer:** advances by 1 on every accepted, non-dropped beat while in scan mode. It wraps from N-1 to 0. It holds in addressed mode.
- **Out-of-range select:** in addressed mode with `iSel` ≥ N (possible when N is not a power of two), the beat is accepted and discarded. `oErr` pulses for one cycle, and state and pointer are unchanged.
- **Transitions:**
  - EMPTY to FULL on accept.
  - FULL to EMPTY on drain without accept.
  - FULL stays FULL on simultaneous drain and accept; the new beat and new `ch_q` load in the same edge.
- **Other boundary rules:**
  - `iReady` bits of non-destination channels are ignored.
  - A mode change while FULL affects only the next accepted beat.
  - Reset while FULL discards the held beat.

## Timing
- Latency is 1 cycle: a beat accepted at edge k appears on `oData`/`oValid` after edge k.
- Throughput is 1 beat per cycle while the destination consumer holds `iReady` high.
- `oValid` and `oData` stay stable while FULL and not drained.
- `oErr` is registered; it is high in the cycle after the dropping accept edge.

## Configuration
- `DE_SELECTOR_STATS_EN`:
  - **Defined:** N 16-bit counters, one per channel, each incremented on a drain to that channel. Counters wrap from 0xFFFF to 0. `oStatCnt` is a combinational read of counter `iStatSel`; an out-of-range `iStatSel` reads 0. All counters clear on reset.
  - **Not defined:** counters, `iStatSel` and `oStatCnt` are absent, and behaviour is otherwise identical.

## Structure
- Package `de_selector_pkg`:
  - mode encoding: `MODE_ADDR` = 0, `MODE_SCAN` = 1;
  - state enum {EMPTY, FULL};
  - `STAT_W` = 16.
- Sub-module `de_selector_rr_ptr`: a parametrised modulo-N wrap counter with enable and synchronous reset. It is used for the scan pointer.

## Test plan
- **Addressed routing:** N=4, addressed mode; send 0xA0–0xA3 with `iSel` 0..3 and all `iReady` = 1. Required: each beat appears one cycle later with `oValid` = 0001, 0010, 0100, 1000; 4 beats in 4 cycles.
- **Back-pressure:** hold `iReady[2]` = 0 with a beat 0x55 held for channel 2. Required: `oReady` = 0 and `oData` stays 0x55. Raise `iReady[2]`: the beat drains in that cycle, and a simultaneously offered 0x66 loads with no bubble.
- **Scan wrap:** N=3, scan mode; send 7 beats. Required: destinations 0,1,2,0,1,2,0 and pointer = 1 afterwards.
- **Out-of-range select:** N=3, `iSel` = 3, data 0x77. Required: `oErr` high for exactly one cycle, `oValid` stays 0, pointer unchanged.
- **Reset mid-operation:** assert `iRst` while FULL. Required: next cycle `oValid` = 0, `oData` = 0, `oReady` = 1, pointer = 0.
- **Stats (with `DE_SELECTOR_STATS_EN`):** deliver 5 beats to channel 1 and 2 to channel 0. Required: `oStatCnt` = 5 at `iStatSel` = 1 and 2 at `iStatSel` = 0. Preload 0xFFFF and deliver one beat: required wrap to 0.
